fwd_hazard_scoreboard: RTL and testbench
========================================

// Module: fwd_hazard_scoreboard
// PURPOSE
//  Parametrised successor to the EX-stage forwarding logic. Tracks in-flight register writers from ID onward,
//  decides forwarding muxes one cycle early (in ID) and registers them to align with EX, and raises load-use /
//  late-result stalls. Sits between ID decode and the ID/EX register; drives EX operand muxes and the ID/IF hold.
// PARAMETERS
//  REG_AW        5  register-index width; index 0 is hardwired zero, never a dependency
//  NUM_SRC       2  source operands per instruction
//  NUM_FWD       2  forwarding taps; sel k=1 is EX/MEM, k=2 MEM/WB, ... k=NUM_FWD oldest; 0 = register file
//  LOAD_MIN_SEL  2  smallest tap from which load data is valid (1..NUM_FWD)
//  CNT_W         32 width of the load-use stall counter
// PORTS
//  clk           in   1                 clock
//  rst           in   1                 synchronous, active-high reset
//  id_valid      in   1                 instruction present in ID
//  id_rs         in   NUM_SRC*REG_AW    source indices, src i at [i*REG_AW +: REG_AW]
//  id_rs_used    in   NUM_SRC           per-source "operand actually read" mask
//  id_rd         in   REG_AW            destination index
//  id_regwrite   in   1                 ID instruction writes id_rd
//  id_is_load    in   1                 ID instruction is a load (result late)
//  pipe_stall    in   1                 global freeze (e.g. memory wait)
//  flush         in   1                 EX redirect: kill instruction in ID
//  hazard_stall  out  1                 combinational: hold PC/IF/ID, inject bubble into EX
//  ex_valid      out  1                 registered: EX holds a real instruction
//  ex_fwd_sel    out  NUM_SRC*SELW      registered operand-mux selects for the EX instruction
//  load_use_cnt  out  CNT_W             cycles spent in hazard_stall (saturating)
// BEHAVIOUR
//  - SELW = $clog2(NUM_FWD+1). Tracker e[0..NUM_FWD-1] = {valid, rd, regwrite, is_load}; e[0] = instr now in EX.
//  - Match(i,j): id_valid & id_rs_used[i] & rs_i!=0 & e[j].valid & e[j].regwrite & e[j].rd==rs_i.
//  - sel_i = j+1 for the smallest matching j (youngest producer wins); 0 if none (RF is write-before-read).
//  - Per-source hazard: matched youngest producer is a load and (j+1) < LOAD_MIN_SEL.
//  - hazard_stall = OR of per-source hazards, gated by !flush; independent of pipe_stall (still reported).
//  - Advance rule each posedge, priority order:
//     rst        : all e[].valid=0, ex_valid=0, ex_fwd_sel=0, load_use_cnt=0.
//     pipe_stall : nothing changes (tracker, ex_*, counter frozen).
//     flush      : shift e[j]<=e[j-1]; e[0]<=bubble; ex_valid=0; ex_fwd_sel=0.
//     hazard     : shift; e[0]<=bubble; ex_valid=0; ex_fwd_sel=0; load_use_cnt+=1 (saturate at all-ones).
//     otherwise  : shift; e[0]<={id_valid,id_rd,id_regwrite&(id_rd!=0),id_is_load}; ex_valid<=id_valid;
//                  ex_fwd_sel<=computed sel.
//  - Oldest entry drops out on shift (its write reaches RF). Stall length for load at distance d = LOAD_MIN_SEL-d;
//    sel recomputed every stalled cycle so the released instruction gets the correct tap (e.g. 2 after 1 stall).
//  - Latency: sel decided in ID, visible on ex_fwd_sel 1 cycle later with the instruction in EX.
//  - Same rs on both sources: each gets identical sel. id_rd==0 writers never recorded as producers.
//  - Reset mid-stall: stall drops immediately (tracker empty); ID instruction proceeds next cycle with sel 0.
// STRUCTURE
//  - Shared pkg riscv_pipe_pkg: FWD_RF=0 / FWD_EXMEM=1 / FWD_MEMWB=2 constants, tracker-entry struct, SELW helper.
//  - Sub-module fwd_dep_tracker: the NUM_FWD-deep entry shift register with hold/bubble controls and flat
//    valid/rd/regwrite/is_load outputs; top holds priority match, hazard, registered selects and counter.
// TESTING
//  - add x5 ; add x6,x5,x5 -> no stall; EX of 2nd: ex_fwd_sel src0=1, src1=1.
//  - add x5 ; nop ; sub x7,x5,x1 -> sub in EX: src0=2, src1=0; x5 old by 3 -> 0.
//  - lw x5 ; add x6,x5,x0 -> hazard_stall=1 exactly 1 cycle, ex_valid=0 that cycle, then src0=2; cnt=1.
//  - add x5 ; add x5 ; or x8,x5,x5 -> youngest wins, both sel=1; writes to x0 then read x0 -> sel 0, no stall.
//  - lw x5 with pipe_stall=1 for 3 cycles, then consumer -> counter frozen during freeze, still exactly 1 stall.
//  - Load-use stall with flush=1 same cycle -> hazard_stall=0, bubble to EX; rst mid-stall -> all outputs 0 next edge.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: forwarding-tap encodings, dependency-tracker flag record and select-width helper.
package riscv_pipe_pkg;

  localparam int FWD_RF    = 0;
  localparam int FWD_EXMEM = 1;
  localparam int FWD_MEMWB = 2;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic is_load;
  } trk_flags_t;

  function automatic int sel_w(input int num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// ID-side request and EX-side forwarding/stall signals of the hazard scoreboard.
interface fwd_hazard_scoreboard_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 32
);
  import riscv_pipe_pkg::*;

  localparam int SELW = sel_w(NUM_FWD);

  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [REG_AW-1:0]         id_rd;
  logic                      id_regwrite;
  logic                      id_is_load;
  logic                      pipe_stall;
  logic                      flush;
  logic                      hazard_stall;
  logic                      ex_valid;
  logic [NUM_SRC*SELW-1:0]   ex_fwd_sel;
  logic [CNT_W-1:0]          load_use_cnt;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load, pipe_stall, flush,
    input  hazard_stall, ex_valid, ex_fwd_sel, load_use_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load, pipe_stall, flush,
    output hazard_stall, ex_valid, ex_fwd_sel, load_use_cnt
  );

endinterface

// File: rtl/fwd_dep_tracker.sv
// Shift register of in-flight register writers; entry 0 is the instruction in EX, the last entry the oldest tap.
module fwd_dep_tracker
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic                      bubble,
  input  logic                      in_valid,
  input  logic [REG_AW-1:0]         in_rd,
  input  logic                      in_regwrite,
  input  logic                      in_is_load,
  output logic [NUM_FWD-1:0]        e_valid,
  output logic [NUM_FWD*REG_AW-1:0] e_rd,
  output logic [NUM_FWD-1:0]        e_regwrite,
  output logic [NUM_FWD-1:0]        e_is_load
);

  trk_flags_t        flags_q [NUM_FWD];
  logic [REG_AW-1:0] rd_q    [NUM_FWD];
  trk_flags_t        in_flags;

  // x0 writers are never recorded as producers
  always_comb begin
    in_flags = '0;
    if (!bubble) begin
      in_flags.valid    = in_valid;
      in_flags.regwrite = in_valid & in_regwrite & (in_rd != '0);
      in_flags.is_load  = in_valid & in_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_FWD; j++) flags_q[j] <= '0;
    end else if (!hold) begin
      flags_q[0] <= in_flags;
      for (int j = 1; j < NUM_FWD; j++) flags_q[j] <= flags_q[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!hold) begin
      rd_q[0] <= in_rd;
      for (int j = 1; j < NUM_FWD; j++) rd_q[j] <= rd_q[j-1];
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_FWD; j++) begin
      e_valid[j]                  = flags_q[j].valid;
      e_regwrite[j]               = flags_q[j].regwrite;
      e_is_load[j]                = flags_q[j].is_load;
      e_rd[j*REG_AW +: REG_AW]    = rd_q[j];
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Decides EX operand forwarding in ID, registers it alongside the instruction, and raises load-use stalls.
module fwd_hazard_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int NUM_SRC      = 2,
  parameter int NUM_FWD      = 2,
  parameter int LOAD_MIN_SEL = 2,
  parameter int CNT_W        = 32
) (
  input logic                    clk,
  input logic                    rst,
  fwd_hazard_scoreboard_if.slave bus
);

  localparam int SELW = sel_w(NUM_FWD);

  logic [NUM_FWD-1:0]        e_valid;
  logic [NUM_FWD*REG_AW-1:0] e_rd;
  logic [NUM_FWD-1:0]        e_regwrite;
  logic [NUM_FWD-1:0]        e_is_load;

  logic [NUM_SRC*SELW-1:0]   sel_p0;
  logic [NUM_SRC-1:0]        src_hz_p0;
  logic                      hz_p0;
  logic                      vld_p1;
  logic [NUM_SRC*SELW-1:0]   fwd_sel_p1;
  logic [CNT_W-1:0]          cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  fwd_dep_tracker #(
    .REG_AW  (REG_AW),
    .NUM_FWD (NUM_FWD)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .hold        (bus.pipe_stall),
    .bubble      (bus.flush | hz_p0),
    .in_valid    (bus.id_valid),
    .in_rd       (bus.id_rd),
    .in_regwrite (bus.id_regwrite),
    .in_is_load  (bus.id_is_load),
    .e_valid     (e_valid),
    .e_rd        (e_rd),
    .e_regwrite  (e_regwrite),
    .e_is_load   (e_is_load)
  );

  // p0 (ID): scan oldest to youngest so the youngest matching producer overrides
  always_comb begin
    sel_p0    = '0;
    src_hz_p0 = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_p0[i*SELW +: SELW] = SELW'(FWD_RF);
      for (int j = NUM_FWD - 1; j >= 0; j--) begin
        if (bus.id_valid && bus.id_rs_used[i] &&
            (bus.id_rs[i*REG_AW +: REG_AW] != '0) &&
            e_valid[j] && e_regwrite[j] &&
            (e_rd[j*REG_AW +: REG_AW] == bus.id_rs[i*REG_AW +: REG_AW])) begin
          sel_p0[i*SELW +: SELW] = SELW'(j + 1);
          src_hz_p0[i]           = e_is_load[j] && ((j + 1) < LOAD_MIN_SEL);
        end
      end
    end
    hz_p0 = (|src_hz_p0) & ~bus.flush;
  end

  // p1 (EX): selects and valid travel with the instruction into EX
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      fwd_sel_p1 <= '0;
      cnt_q      <= '0;
    end else if (!bus.pipe_stall) begin
      if (bus.flush || hz_p0) begin
        vld_p1     <= 1'b0;
        fwd_sel_p1 <= '0;
        if (hz_p0) cnt_q <= sat_inc(cnt_q);
      end else begin
        vld_p1     <= bus.id_valid;
        fwd_sel_p1 <= sel_p0;
      end
    end
  end

  assign bus.hazard_stall = hz_p0;
  assign bus.ex_valid     = vld_p1;
  assign bus.ex_fwd_sel   = fwd_sel_p1;
  assign bus.load_use_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed pipeline scenarios plus randomized traffic against an in-flight-slot reference model.
module tb_fwd_hazard_scoreboard;

  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int NUM_FWD = 2;
  localparam int LMS     = 2;
  localparam int CNT_W   = 4;
  localparam int SELW    = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_hazard_scoreboard_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) bus ();

  fwd_hazard_scoreboard #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .LOAD_MIN_SEL(LMS), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: queue of pipeline slots ahead of ID, youngest at the front
  typedef struct { bit v; bit [REG_AW-1:0] rd; bit wr; bit ld; } slot_t;
  slot_t slots[$];
  bit    m_hz;
  bit    m_ex_valid;
  int    m_sel   [NUM_SRC];
  int    nxt_sel [NUM_SRC];
  int    m_cnt;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic model_eval();
    bit hz_any;
    bit [REG_AW-1:0] rs;
    hz_any = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs = bus.id_rs[i*REG_AW +: REG_AW];
      nxt_sel[i] = 0;
      if (bus.id_valid && bus.id_rs_used[i] && rs != 0) begin
        for (int d = 0; d < slots.size(); d++) begin
          if (slots[d].v && slots[d].wr && slots[d].rd == rs) begin
            nxt_sel[i] = d + 1;
            if (slots[d].ld && (d + 1) < LMS) hz_any = 1'b1;
            break;
          end
        end
      end
    end
    m_hz = hz_any && !bus.flush;
  endtask

  task automatic model_clock();
    slot_t s;
    s.v = 0; s.rd = 0; s.wr = 0; s.ld = 0;
    if (rst) begin
      slots.delete();
      for (int j = 0; j < NUM_FWD; j++) slots.push_back(s);
      m_ex_valid = 0;
      for (int i = 0; i < NUM_SRC; i++) m_sel[i] = 0;
      m_cnt = 0;
    end else if (!bus.pipe_stall) begin
      if (bus.flush || m_hz) begin
        m_ex_valid = 0;
        for (int i = 0; i < NUM_SRC; i++) m_sel[i] = 0;
        if (m_hz && m_cnt < CNT_MAX) m_cnt++;
      end else begin
        s.v  = bus.id_valid;
        s.rd = bus.id_rd;
        s.wr = bus.id_regwrite && (bus.id_rd != 0);
        s.ld = bus.id_is_load;
        m_ex_valid = bus.id_valid;
        for (int i = 0; i < NUM_SRC; i++) m_sel[i] = nxt_sel[i];
      end
      slots.push_front(s);
      void'(slots.pop_back());
    end
  endtask

  task automatic tick();
    model_eval();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic set_id(bit v, int rs0, int rs1, bit [1:0] used, int rd, bit rw, bit ld);
    bus.id_valid    = v;
    bus.id_rs       = {REG_AW'(rs1), REG_AW'(rs0)};
    bus.id_rs_used  = used;
    bus.id_rd       = REG_AW'(rd);
    bus.id_regwrite = rw;
    bus.id_is_load  = ld;
    bus.pipe_stall  = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic alu(int rd, int rs0, int rs1);
    set_id(1'b1, rs0, rs1, 2'b11, rd, 1'b1, 1'b0);
  endtask

  task automatic lw(int rd, int rs0);
    set_id(1'b1, rs0, 0, 2'b01, rd, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu(5, 5, 5);
    tick();
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %0b want 0", bus.ex_valid); end
    n_checks++; if (bus.ex_fwd_sel !== '0) begin n_fail++; $display("FAIL reset_sel: got %0h want 0", bus.ex_fwd_sel); end
    n_checks++; if (bus.load_use_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.load_use_cnt); end
    rst = 1'b0;
    settle();
    n_checks++; if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_hz: got %0b want 0", bus.hazard_stall); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    alu(5, 1, 2); tick();
    alu(6, 5, 5); settle();
    n_checks++; if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_hz: got %0b want 0", bus.hazard_stall); end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_ex_valid: got %0b want 1", bus.ex_valid); end
    n_checks++; if (bus.ex_fwd_sel[0 +: SELW] !== 2'd1) begin n_fail++; $display("FAIL b2b_sel0: got %0d want 1", bus.ex_fwd_sel[0 +: SELW]); end
    n_checks++; if (bus.ex_fwd_sel[SELW +: SELW] !== 2'd1) begin n_fail++; $display("FAIL b2b_sel1: got %0d want 1", bus.ex_fwd_sel[SELW +: SELW]); end
  endtask

  task automatic test_distance();
    do_reset();
    alu(5, 1, 2); tick();
    alu(0, 0, 0); tick();
    alu(7, 5, 1); tick();
    n_checks++; if (bus.ex_fwd_sel[0 +: SELW] !== 2'd2) begin n_fail++; $display("FAIL dist2_sel0: got %0d want 2", bus.ex_fwd_sel[0 +: SELW]); end
    n_checks++; if (bus.ex_fwd_sel[SELW +: SELW] !== 2'd0) begin n_fail++; $display("FAIL dist2_sel1: got %0d want 0", bus.ex_fwd_sel[SELW +: SELW]); end
    do_reset();
    alu(5, 1, 2); tick();
    alu(0, 0, 0); tick();
    alu(0, 0, 0); tick();
    alu(7, 5, 5); tick();
    n_checks++; if (bus.ex_fwd_sel !== '0) begin n_fail++; $display("FAIL dist3_sel: got %0h want 0", bus.ex_fwd_sel); end
    n_checks++; if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL dist3_ex_valid: got %0b want 1", bus.ex_valid); end
  endtask

  task automatic test_load_use();
    do_reset();
    lw(5, 1); tick();
    alu(6, 5, 0); settle();
    n_checks++; if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL lu_hz_on: got %0b want 1", bus.hazard_stall); end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got %0b want 0", bus.ex_valid); end
    settle();
    n_checks++; if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL lu_hz_off: got %0b want 0", bus.hazard_stall); end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL lu_release_valid: got %0b want 1", bus.ex_valid); end
    n_checks++; if (bus.ex_fwd_sel[0 +: SELW] !== 2'd2) begin n_fail++; $display("FAIL lu_sel0: got %0d want 2", bus.ex_fwd_sel[0 +: SELW]); end
    n_checks++; if (bus.ex_fwd_sel[SELW +: SELW] !== 2'd0) begin n_fail++; $display("FAIL lu_sel1: got %0d want 0", bus.ex_fwd_sel[SELW +: SELW]); end
    n_checks++; if (bus.load_use_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d want 1", bus.load_use_cnt); end
  endtask

  task automatic test_youngest_x0();
    do_reset();
    alu(5, 1, 2); tick();
    alu(5, 3, 4); tick();
    alu(8, 5, 5); tick();
    n_checks++; if (bus.ex_fwd_sel !== {2'd1, 2'd1}) begin n_fail++; $display("FAIL youngest_sel: got %0h want 5", bus.ex_fwd_sel); end
    alu(0, 1, 2); tick();
    lw(0, 1); tick();
    alu(9, 0, 0); settle();
    n_checks++; if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL x0_hz: got %0b want 0", bus.hazard_stall); end
    tick();
    n_checks++; if (bus.ex_fwd_sel !== '0) begin n_fail++; $display("FAIL x0_sel: got %0h want 0", bus.ex_fwd_sel); end
  endtask

  task automatic test_freeze();
    do_reset();
    lw(5, 1); tick();
    for (int k = 0; k < 3; k++) begin
      alu(6, 5, 0);
      bus.pipe_stall = 1'b1;
      settle();
      n_checks++; if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL frz_hz[%0d]: got %0b want 1", k, bus.hazard_stall); end
      tick();
      n_checks++; if (bus.load_use_cnt !== 4'd0 || bus.ex_valid !== 1'b1) begin
        n_fail++; $display("FAIL frz_hold[%0d]: cnt %0d valid %0b want cnt 0 valid 1", k, bus.load_use_cnt, bus.ex_valid);
      end
    end
    alu(6, 5, 0); settle();
    n_checks++; if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL frz_hz_rel: got %0b want 1", bus.hazard_stall); end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0 || bus.load_use_cnt !== 4'd1) begin
      n_fail++; $display("FAIL frz_stall: valid %0b cnt %0d want valid 0 cnt 1", bus.ex_valid, bus.load_use_cnt);
    end
    settle(); tick();
    n_checks++; if (bus.ex_fwd_sel[0 +: SELW] !== 2'd2 || bus.load_use_cnt !== 4'd1) begin
      n_fail++; $display("FAIL frz_done: sel0 %0d cnt %0d want sel0 2 cnt 1", bus.ex_fwd_sel[0 +: SELW], bus.load_use_cnt);
    end
  endtask

  task automatic test_flush_reset();
    do_reset();
    lw(5, 1); tick();
    alu(6, 5, 0); bus.flush = 1'b1; settle();
    n_checks++; if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL flush_hz: got %0b want 0", bus.hazard_stall); end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_fwd_sel !== '0 || bus.load_use_cnt !== 4'd0) begin
      n_fail++; $display("FAIL flush_bubble: valid %0b sel %0h cnt %0d want 0 0 0", bus.ex_valid, bus.ex_fwd_sel, bus.load_use_cnt);
    end
    alu(6, 5, 0); settle(); tick();
    n_checks++; if (bus.ex_fwd_sel[0 +: SELW] !== 2'd2) begin n_fail++; $display("FAIL flush_after_sel0: got %0d want 2", bus.ex_fwd_sel[0 +: SELW]); end
    do_reset();
    lw(5, 1); tick();
    alu(6, 5, 0); settle();
    rst = 1'b1; tick();
    n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_fwd_sel !== '0 || bus.load_use_cnt !== 4'd0) begin
      n_fail++; $display("FAIL rst_mid: valid %0b sel %0h cnt %0d want 0 0 0", bus.ex_valid, bus.ex_fwd_sel, bus.load_use_cnt);
    end
    rst = 1'b0; settle();
    n_checks++; if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hz: got %0b want 0", bus.hazard_stall); end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b1 || bus.ex_fwd_sel !== '0) begin
      n_fail++; $display("FAIL rst_mid_proceed: valid %0b sel %0h want 1 0", bus.ex_valid, bus.ex_fwd_sel);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < CNT_MAX + 2; k++) begin
      lw(5, 1); tick();
      alu(6, 5, 5); tick();
      tick();
    end
    n_checks++; if (bus.load_use_cnt !== 4'(CNT_MAX)) begin n_fail++; $display("FAIL sat_cnt: got %0d want %0d", bus.load_use_cnt, CNT_MAX); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             2'($urandom_range(0, 3)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.pipe_stall = ($urandom_range(0, 7) == 0);
      bus.flush      = ($urandom_range(0, 9) == 0);
      rst            = ($urandom_range(0, 63) == 0);
      settle();
      n_checks++; if (bus.hazard_stall !== m_hz) begin n_fail++; $display("FAIL rnd_hz c%0d: got %0b want %0b", c, bus.hazard_stall, m_hz); end
      tick();
      n_checks++; if (bus.ex_valid !== m_ex_valid) begin n_fail++; $display("FAIL rnd_valid c%0d: got %0b want %0b", c, bus.ex_valid, m_ex_valid); end
      for (int i = 0; i < NUM_SRC; i++) begin
        n_checks++; if (bus.ex_fwd_sel[i*SELW +: SELW] !== SELW'(m_sel[i])) begin
          n_fail++; $display("FAIL rnd_sel%0d c%0d: got %0d want %0d", i, c, bus.ex_fwd_sel[i*SELW +: SELW], m_sel[i]);
        end
      end
      n_checks++; if (bus.load_use_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, bus.load_use_cnt, m_cnt); end
    end
    rst = 1'b0;
  endtask

  initial begin
    slot_t s0;
    s0.v = 0; s0.rd = 0; s0.wr = 0; s0.ld = 0;
    for (int j = 0; j < NUM_FWD; j++) slots.push_back(s0);
    m_hz = 0; m_ex_valid = 0; m_cnt = 0;
    for (int i = 0; i < NUM_SRC; i++) begin m_sel[i] = 0; nxt_sel[i] = 0; end
    rst = 1'b1;
    set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use();
    test_youngest_x0();
    test_freeze();
    test_flush_reset();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
